// File: rtl/alu_issue_seq_if.sv
// Signal bundle between register-read, the ALU issue sequencer, the RV32I ALU and writeback.
// The sequencer attaches as slave; the surrounding pipeline (or a bench) attaches as master.
interface alu_issue_seq_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [XLEN-1:0]   in_rs1;
  logic [XLEN-1:0]   in_rs2;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [XLEN-1:0]   alu_a;
  logic [XLEN-1:0]   alu_b;
  logic              alu_bsel;
  logic [XLEN-1:0]   alu_result;
  logic              res_valid;
  logic              res_ready;
  logic [XLEN-1:0]   res_data;
  logic [4:0]        res_rd;
  logic              res_we;
  logic              res_err;

  modport slave (
    input  in_valid, in_instr, in_rs1, in_rs2, alu_result, res_ready,
    output in_ready, alu_ctrl, alu_a, alu_b, alu_bsel,
           res_valid, res_data, res_rd, res_we, res_err
  );

  modport master (
    output in_valid, in_instr, in_rs1, in_rs2, alu_result, res_ready,
    input  in_ready, alu_ctrl, alu_a, alu_b, alu_bsel,
           res_valid, res_data, res_rd, res_we, res_err
  );
endinterface

// File: rtl/alu_issue_seq.sv
// Issue sequencer for the RV32I integer ALU: decode OP/OP-IMM, drive the ALU for one cycle, hand the result to writeback.
// Optional macro ALU_ISSUE_ILLEGAL_TRAP_EN: flag illegal instructions on res_err and block further issue until reset.
module alu_issue_seq #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_issue_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            state_q;
  logic [CTRL_W-1:0] aluCtrl_q;
  logic [XLEN-1:0]   aluA_q;
  logic [XLEN-1:0]   aluB_q;
  logic              aluBsel_q;
  logic              legal_q;
  logic [4:0]        rd_q;
  logic              resValid_q;
  logic [XLEN-1:0]   resData_q;
  logic [4:0]        resRd_q;
  logic              resWe_q;

  logic [CTRL_W-1:0] ctrl_d;
  logic [XLEN-1:0]   b_d;
  logic              bsel_d;
  logic              legal_d;
  logic              inReady;
  logic              accept;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [XLEN-1:0]   immExt;
  logic              unusedRs1Field;

  assign opcode         = bus.in_instr[6:0];
  assign funct3         = bus.in_instr[14:12];
  assign funct7         = bus.in_instr[31:25];
  assign immExt         = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign unusedRs1Field = ^bus.in_instr[19:15];

  // Code 0 doubles as the illegal marker, so legality falls out of the decode.
  always_comb begin
    ctrl_d = '0;
    bsel_d = 1'b0;
    if (opcode == 7'b0110011) begin
      case ({funct7, funct3})
        {7'b0000000, 3'b000}: ctrl_d = CTRL_W'(1);
        {7'b0100000, 3'b000}: ctrl_d = CTRL_W'(9);
        {7'b0000000, 3'b001}: ctrl_d = CTRL_W'(17);
        {7'b0000000, 3'b010}: ctrl_d = CTRL_W'(10);
        {7'b0000000, 3'b011}: ctrl_d = CTRL_W'(12);
        {7'b0000000, 3'b100}: ctrl_d = CTRL_W'(5);
        {7'b0000000, 3'b101}: ctrl_d = CTRL_W'(18);
        {7'b0100000, 3'b101}: ctrl_d = CTRL_W'(19);
        {7'b0000000, 3'b110}: ctrl_d = CTRL_W'(3);
        {7'b0000000, 3'b111}: ctrl_d = CTRL_W'(7);
        default:              ctrl_d = '0;
      endcase
    end else if (opcode == 7'b0010011) begin
      bsel_d = 1'b1;
      case (funct3)
        3'b000:  ctrl_d = CTRL_W'(2);
        3'b010:  ctrl_d = CTRL_W'(11);
        3'b011:  ctrl_d = CTRL_W'(13);
        3'b100:  ctrl_d = CTRL_W'(6);
        3'b110:  ctrl_d = CTRL_W'(4);
        3'b111:  ctrl_d = CTRL_W'(8);
        3'b001:  ctrl_d = (funct7 == 7'b0000000) ? CTRL_W'(14) : '0;
        3'b101: begin
          if (funct7 == 7'b0000000)      ctrl_d = CTRL_W'(15);
          else if (funct7 == 7'b0100000) ctrl_d = CTRL_W'(16);
          else                           ctrl_d = '0;
        end
        default: ctrl_d = '0;
      endcase
    end
  end

  assign legal_d = (ctrl_d != '0);
  assign b_d     = bsel_d ? immExt : bus.in_rs2;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic trap_q;
  logic resErr_q;
  assign bus.res_err = resErr_q;
`else
  assign bus.res_err = 1'b0;
`endif

  // A result still waiting in DONE can be retired and replaced in the same cycle.
  always_comb begin
    inReady = 1'b0;
    case (state_q)
      IDLE:    inReady = 1'b1;
      DONE:    inReady = bus.res_ready;
      default: inReady = 1'b0;
    endcase
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    if (trap_q) inReady = 1'b0;
`endif
  end

  assign accept = bus.in_valid & inReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      aluCtrl_q  <= '0;
      aluA_q     <= '0;
      aluB_q     <= '0;
      aluBsel_q  <= 1'b0;
      legal_q    <= 1'b0;
      rd_q       <= '0;
      resValid_q <= 1'b0;
      resData_q  <= '0;
      resRd_q    <= '0;
      resWe_q    <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      trap_q     <= 1'b0;
      resErr_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE:    if (accept) state_q <= EXEC;
        EXEC:    state_q <= DONE;
        DONE:    if (bus.res_ready) state_q <= accept ? EXEC : IDLE;
        default: state_q <= IDLE;
      endcase

      if (accept) begin
        aluCtrl_q <= ctrl_d;
        aluA_q    <= bus.in_rs1;
        aluB_q    <= b_d;
        aluBsel_q <= bsel_d;
        legal_q   <= legal_d;
        rd_q      <= bus.in_instr[11:7];
      end else if (state_q == EXEC) begin
        aluCtrl_q <= '0;
        aluA_q    <= '0;
        aluB_q    <= '0;
        aluBsel_q <= 1'b0;
      end

      // Illegal instructions still retire, but with zero data and no write.
      if (state_q == EXEC) begin
        resValid_q <= 1'b1;
        resData_q  <= legal_q ? bus.alu_result : '0;
        resRd_q    <= rd_q;
        resWe_q    <= legal_q && (rd_q != 5'd0);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        resErr_q   <= ~legal_q;
        if (!legal_q) trap_q <= 1'b1;
`endif
      end else if (state_q == DONE && bus.res_ready) begin
        resValid_q <= 1'b0;
        resWe_q    <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        resErr_q   <= 1'b0;
`endif
      end
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.alu_ctrl  = aluCtrl_q;
  assign bus.alu_a     = aluA_q;
  assign bus.alu_b     = aluB_q;
  assign bus.alu_bsel  = aluBsel_q;
  assign bus.res_valid = resValid_q;
  assign bus.res_data  = resData_q;
  assign bus.res_rd    = resRd_q;
  assign bus.res_we    = resWe_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: an ALU stub, a transaction-level model checked every cycle, and directed vectors.
// Honours ALU_ISSUE_ILLEGAL_TRAP_EN when it is defined for the build.
module tb_alu_issue_seq;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        bsel;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        err;
    logic        ill;
  } item_t;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   cycleCnt = 0;
  int   hsLast = 0;
  int   hsPrev = 0;

  logic  execV = 1'b0;
  logic  outV = 1'b0;
  logic  trapM = 1'b0;
  item_t execI;
  item_t outI;

  always #5 clk = ~clk;

  alu_issue_seq_if #(.XLEN(32), .CTRL_W(5)) bus ();

  alu_issue_seq #(.XLEN(32), .CTRL_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Stand-in for the RV32I ALU, keyed purely on the control code.
  function automatic logic [31:0] aluStub(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      5'd1, 5'd2:   return a + b;
      5'd9:         return a - b;
      5'd17, 5'd14: return a << b[4:0];
      5'd10, 5'd11: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd12, 5'd13: return (a < b) ? 32'd1 : 32'd0;
      5'd5, 5'd6:   return a ^ b;
      5'd18, 5'd15: return a >> b[4:0];
      5'd19, 5'd16: return 32'($signed(a) >>> b[4:0]);
      5'd3, 5'd4:   return a | b;
      5'd7, 5'd8:   return a & b;
      default:      return 32'hDEADBEEF;
    endcase
  endfunction

  assign bus.alu_result = aluStub(bus.alu_ctrl, bus.alu_a, bus.alu_b);

  // Expected outcome of one instruction from its RV32I meaning.
  function automatic item_t predict(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
    item_t       it;
    logic [31:0] imm;
    logic [6:0]  f7;
    logic [2:0]  f3;
    bit          ok;
    imm = {{20{instr[31]}}, instr[31:20]};
    f7 = instr[31:25];
    f3 = instr[14:12];
    it = '0;
    it.a = rs1;
    it.rd = instr[11:7];
    it.bsel = (instr[6:0] == 7'h13);
    it.b = it.bsel ? imm : rs2;
    ok = 1'b1;
    if (instr[6:0] == 7'h33) begin
      if (f7 == 7'h00 && f3 == 3'd0)      begin it.ctrl = 5'd1;  it.data = rs1 + rs2; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin it.ctrl = 5'd9;  it.data = rs1 - rs2; end
      else if (f7 == 7'h00 && f3 == 3'd1) begin it.ctrl = 5'd17; it.data = rs1 << rs2[4:0]; end
      else if (f7 == 7'h00 && f3 == 3'd2) begin it.ctrl = 5'd10; it.data = {31'd0, $signed(rs1) < $signed(rs2)}; end
      else if (f7 == 7'h00 && f3 == 3'd3) begin it.ctrl = 5'd12; it.data = {31'd0, rs1 < rs2}; end
      else if (f7 == 7'h00 && f3 == 3'd4) begin it.ctrl = 5'd5;  it.data = rs1 ^ rs2; end
      else if (f7 == 7'h00 && f3 == 3'd5) begin it.ctrl = 5'd18; it.data = rs1 >> rs2[4:0]; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin it.ctrl = 5'd19; it.data = 32'($signed(rs1) >>> rs2[4:0]); end
      else if (f7 == 7'h00 && f3 == 3'd6) begin it.ctrl = 5'd3;  it.data = rs1 | rs2; end
      else if (f7 == 7'h00 && f3 == 3'd7) begin it.ctrl = 5'd7;  it.data = rs1 & rs2; end
      else ok = 1'b0;
    end else if (instr[6:0] == 7'h13) begin
      if (f3 == 3'd0)                     begin it.ctrl = 5'd2;  it.data = rs1 + imm; end
      else if (f3 == 3'd2)                begin it.ctrl = 5'd11; it.data = {31'd0, $signed(rs1) < $signed(imm)}; end
      else if (f3 == 3'd3)                begin it.ctrl = 5'd13; it.data = {31'd0, rs1 < imm}; end
      else if (f3 == 3'd4)                begin it.ctrl = 5'd6;  it.data = rs1 ^ imm; end
      else if (f3 == 3'd6)                begin it.ctrl = 5'd4;  it.data = rs1 | imm; end
      else if (f3 == 3'd7)                begin it.ctrl = 5'd8;  it.data = rs1 & imm; end
      else if (f3 == 3'd1 && f7 == 7'h00) begin it.ctrl = 5'd14; it.data = rs1 << imm[4:0]; end
      else if (f3 == 3'd5 && f7 == 7'h00) begin it.ctrl = 5'd15; it.data = rs1 >> imm[4:0]; end
      else if (f3 == 3'd5 && f7 == 7'h20) begin it.ctrl = 5'd16; it.data = 32'($signed(rs1) >>> imm[4:0]); end
      else ok = 1'b0;
    end else begin
      ok = 1'b0;
    end
    if (!ok) begin
      it.ctrl = 5'd0;
      it.data = 32'd0;
    end
    it.ill = !ok;
    it.we = ok && (it.rd != 5'd0);
    it.err = TRAP_EN && !ok;
    return it;
  endfunction

  function automatic logic [31:0] rType(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] iType(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  // Every cycle: compare DUT against the model, then advance the model by one clock.
  always @(negedge clk) begin
    logic  expReady;
    item_t e;
    cycleCnt <= cycleCnt + 1;
    if (!rst_n) begin
      checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd1);
      checkOutput("rst_alu_ctrl",  32'(bus.alu_ctrl),  32'd0);
      checkOutput("rst_alu_a",     bus.alu_a,          32'd0);
      checkOutput("rst_alu_b",     bus.alu_b,          32'd0);
      checkOutput("rst_alu_bsel",  32'(bus.alu_bsel),  32'd0);
      checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
      checkOutput("rst_res_data",  bus.res_data,       32'd0);
      checkOutput("rst_res_rd",    32'(bus.res_rd),    32'd0);
      checkOutput("rst_res_we",    32'(bus.res_we),    32'd0);
      checkOutput("rst_res_err",   32'(bus.res_err),   32'd0);
      execV <= 1'b0;
      outV  <= 1'b0;
      trapM <= 1'b0;
    end else begin
      expReady = !execV && !trapM && (!outV || bus.res_ready);
      e = execV ? execI : '0;
      checkOutput("in_ready",  32'(bus.in_ready),  32'(expReady));
      checkOutput("alu_ctrl",  32'(bus.alu_ctrl),  32'(e.ctrl));
      checkOutput("alu_a",     bus.alu_a,          e.a);
      checkOutput("alu_b",     bus.alu_b,          e.b);
      checkOutput("alu_bsel",  32'(bus.alu_bsel),  32'(e.bsel));
      checkOutput("res_valid", 32'(bus.res_valid), 32'(outV));
      if (outV) begin
        checkOutput("res_data", bus.res_data,     outI.data);
        checkOutput("res_rd",   32'(bus.res_rd),  32'(outI.rd));
        checkOutput("res_we",   32'(bus.res_we),  32'(outI.we));
        checkOutput("res_err",  32'(bus.res_err), 32'(outI.err));
      end
      if (outV && bus.res_ready) begin
        hsPrev <= hsLast;
        hsLast <= cycleCnt;
      end
      if (execV) begin
        outI <= execI;
        outV <= 1'b1;
        if (execI.ill && TRAP_EN) trapM <= 1'b1;
      end else if (outV && bus.res_ready) begin
        outV <= 1'b0;
      end
      execV <= bus.in_valid && expReady;
      if (bus.in_valid && expReady) execI <= predict(bus.in_instr, bus.in_rs1, bus.in_rs2);
    end
  end

  task automatic applyStimulus(input bit v, input logic [31:0] instr, input logic [31:0] rs1,
                               input logic [31:0] rs2, input bit rr);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.res_ready = rr;
  endtask

  task automatic resetPulse();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] tbl [16];
    logic [31:0] illTbl [4];
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.res_ready = 1'b0;

    // Reset, then release with nothing offered.
    repeat (2) @(negedge clk);
    checkOutput("lit_rst_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("lit_rst_valid", 32'(bus.res_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("lit_idle_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("lit_idle_valid", 32'(bus.res_valid), 32'd0);

    // ADD x3,x1,x2 with 5 + 7.
    applyStimulus(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("lit_add_ctrl", 32'(bus.alu_ctrl), 32'd1);
    checkOutput("lit_add_bsel", 32'(bus.alu_bsel), 32'd0);
    checkOutput("lit_add_b",    bus.alu_b,         32'd7);
    @(negedge clk);
    checkOutput("lit_add_valid", 32'(bus.res_valid), 32'd1);
    checkOutput("lit_add_data",  bus.res_data,       32'd12);
    checkOutput("lit_add_rd",    32'(bus.res_rd),    32'd3);
    checkOutput("lit_add_we",    32'(bus.res_we),    32'd1);

    // SUB with three cycles of writeback backpressure.
    applyStimulus(1'b1, 32'h402081B3, 32'd5, 32'd7, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("lit_sub_ctrl", 32'(bus.alu_ctrl), 32'd9);
    repeat (3) begin
      @(negedge clk);
      checkOutput("lit_sub_data",  bus.res_data,      32'hFFFFFFFE);
      checkOutput("lit_sub_ready", 32'(bus.in_ready), 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("lit_sub_release", 32'(bus.in_ready), 32'd1);

    // ADDI then SRAI then SRAI to x0, each issued on the previous handoff.
    applyStimulus(1'b1, 32'hFFF00293, 32'd0, 32'h12345678, 1'b1);
    applyStimulus(1'b1, 32'h4040D313, 32'h80000000, 32'h12345678, 1'b1);
    @(negedge clk);
    checkOutput("lit_addi_b",    bus.alu_b,         32'hFFFFFFFF);
    checkOutput("lit_addi_bsel", 32'(bus.alu_bsel), 32'd1);
    checkOutput("lit_addi_ctrl", 32'(bus.alu_ctrl), 32'd2);
    applyStimulus(1'b1, 32'h4040D313, 32'h80000000, 32'h12345678, 1'b1);
    @(negedge clk);
    checkOutput("lit_addi_data", bus.res_data,    32'hFFFFFFFF);
    checkOutput("lit_addi_we",   32'(bus.res_we), 32'd1);
    applyStimulus(1'b1, 32'h4040D013, 32'h80000000, 32'h12345678, 1'b1);
    @(negedge clk);
    checkOutput("lit_srai_ctrl", 32'(bus.alu_ctrl), 32'd16);
    checkOutput("lit_srai_b",    bus.alu_b,         32'h00000404);
    applyStimulus(1'b1, 32'h4040D013, 32'h80000000, 32'h12345678, 1'b1);
    @(negedge clk);
    checkOutput("lit_srai_data", bus.res_data,    32'hF8000000);
    checkOutput("lit_srai_rd",   32'(bus.res_rd), 32'd6);
    applyStimulus(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("lit_spacing", 32'(hsLast - hsPrev), 32'd2);
    @(negedge clk);
    checkOutput("lit_srai0_data", bus.res_data,    32'hF8000000);
    checkOutput("lit_srai0_we",   32'(bus.res_we), 32'd0);

    // All-zero word is illegal.
    applyStimulus(1'b1, 32'h00000000, 32'd3, 32'd4, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("lit_ill_ctrl", 32'(bus.alu_ctrl), 32'd0);
    @(negedge clk);
    checkOutput("lit_ill_valid", 32'(bus.res_valid), 32'd1);
    checkOutput("lit_ill_data",  bus.res_data,       32'd0);
    checkOutput("lit_ill_we",    32'(bus.res_we),    32'd0);
    checkOutput("lit_ill_err",   32'(bus.res_err),   32'(TRAP_EN));
    repeat (3) applyStimulus(1'b1, 32'h002081B3, 32'd1, 32'd2, 1'b1);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    @(negedge clk);
    checkOutput("lit_trap_ready", 32'(bus.in_ready), 32'd0);
`endif
    applyStimulus(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
    repeat (3) @(negedge clk);
    resetPulse();

    // Reset while an instruction sits in EXEC: nothing may come out.
    applyStimulus(1'b1, rType(7'h00, 5'd2, 5'd1, 3'd2, 5'd4), 32'd1, 32'd2, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("lit_midrst_valid", 32'(bus.res_valid), 32'd0);

    // Remaining legal decodes.
    tbl[0]  = rType(7'h00, 5'd2, 5'd1, 3'd1, 5'd10);
    tbl[1]  = rType(7'h00, 5'd2, 5'd1, 3'd2, 5'd11);
    tbl[2]  = rType(7'h00, 5'd2, 5'd1, 3'd3, 5'd12);
    tbl[3]  = rType(7'h00, 5'd2, 5'd1, 3'd4, 5'd13);
    tbl[4]  = rType(7'h00, 5'd2, 5'd1, 3'd5, 5'd14);
    tbl[5]  = rType(7'h20, 5'd2, 5'd1, 3'd5, 5'd15);
    tbl[6]  = rType(7'h00, 5'd2, 5'd1, 3'd6, 5'd16);
    tbl[7]  = rType(7'h00, 5'd2, 5'd1, 3'd7, 5'd17);
    tbl[8]  = iType(12'hFFD, 5'd1, 3'd2, 5'd18);
    tbl[9]  = iType(12'hFFD, 5'd1, 3'd3, 5'd19);
    tbl[10] = iType(12'h0F0, 5'd1, 3'd4, 5'd20);
    tbl[11] = iType(12'h700, 5'd1, 3'd6, 5'd21);
    tbl[12] = iType(12'h0FF, 5'd1, 3'd7, 5'd22);
    tbl[13] = iType(12'h005, 5'd1, 3'd1, 5'd23);
    tbl[14] = iType(12'h008, 5'd1, 3'd5, 5'd24);
    tbl[15] = iType(12'h7FF, 5'd1, 3'd0, 5'd0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, tbl[i], 32'h800000F3, 32'h00000005, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
    end

    // Near-miss encodings that must decode as illegal.
    illTbl[0] = rType(7'h01, 5'd2, 5'd1, 3'd0, 5'd7);
    illTbl[1] = iType(12'h405, 5'd1, 3'd1, 5'd7);
    illTbl[2] = iType(12'h605, 5'd1, 3'd5, 5'd7);
    illTbl[3] = 32'h00002083;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, illTbl[i], 32'h11111111, 32'h22222222, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
      resetPulse();
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Issue sequencer in front of the RV32I integer ALU (RISCV_ALU).
- Accepts one OP / OP-IMM instruction with its register operands over a valid/ready handshake.
- Decodes the instruction into the 5-bit ALU control code, drives the ALU for exactly one cycle, captures the result and presents it to writeback over a second valid/ready handshake.
- Sits between the register-read stage and writeback.

Parameters:
XLEN, 32, datapath width of operands and result
CTRL_W, 5, width of ALU control code

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction/operands valid
in_ready  out  1  sequencer can accept
in_instr  in  32  RV32I instruction word
in_rs1  in  XLEN  rs1 value
in_rs2  in  XLEN  rs2 value
alu_ctrl  out  CTRL_W  ALU operation code
alu_a  out  XLEN  ALU operand A
alu_b  out  XLEN  ALU operand B (rs2 or immediate)
alu_bsel  out  1  1 = alu_b carries immediate
alu_result  in  XLEN  combinational ALU output
res_valid  out  1  result valid
res_ready  in  1  writeback accepts result
res_data  out  XLEN  captured result
res_rd  out  5  destination register
res_we  out  1  register write enable
res_err  out  1  illegal instruction flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE. Every output is 0 except in_ready=1.
- FSM states: IDLE, EXEC, DONE.
- in_ready is 1 in IDLE, and 1 in DONE only when res_ready=1. It is 0 in EXEC.
- Accept (in_valid & in_ready at edge T):
  - Register rs1, rs2, decoded code, immediate, rd and legality.
  - Go to EXEC.
- EXEC (cycle T+1):
  - alu_ctrl = decoded code, alu_a = rs1.
  - alu_b = rs2 for R-type; alu_b = sign-extended instr[31:20] for I-type (shift immediates pass the same field, shamt = low 5 bits).
  - alu_bsel = 1 for I-type.
  - alu_result is sampled into res_data at the end of T+1. Go to DONE.
- DONE: res_valid=1 from T+2; res_data, res_rd and res_we are held stable until res_ready=1.
- alu_ctrl, alu_a, alu_b and alu_bsel are 0 outside EXEC.
- Leaving DONE:
  - res_ready=1 and in_valid=1: accept the new instruction in the same cycle and go to EXEC.
  - res_ready=1 and in_valid=0: go to IDLE.
  - Peak throughput is 1 instruction per 2 cycles.
- Decode, R-type (opcode 0110011, code by funct3/funct7):
  - 000/0000000 ADD=1, 000/0100000 SUB=9
  - 001/0000000 SLL=17
  - 010/0000000 SLT=10, 011/0000000 SLTU=12
  - 100/0000000 XOR=5
  - 101/0000000 SRL=18, 101/0100000 SRA=19
  - 110/0000000 OR=3, 111/0000000 AND=7
- Decode, I-type (opcode 0010011):
  - 000 ADDI=2, 010 SLTI=11, 011 SLTIU=13
  - 100 XORI=6, 110 ORI=4, 111 ANDI=8
  - 001 SLLI=14, requires imm[11:5]=0000000
  - 101 SRLI=15 (imm[11:5]=0000000), SRAI=16 (imm[11:5]=0100000)
- Any other opcode/funct combination is illegal: code 0, res_data=0, res_we=0.
- res_rd = instr[11:7]. res_we = legal & (rd != 0). rd=x0 still sequences normally but res_we=0.
- Reset mid-operation: the in-flight instruction is discarded and no result is presented.

Optional Feature:
- Macro ALU_ISSUE_ILLEGAL_TRAP_EN.
- Defined:
  - Illegal instruction gives res_err=1 with its res_valid.
  - A sticky internal flag blocks further accepts (in_ready=0) until rst_n.
- Undefined: res_err tied 0; illegal instructions complete silently with res_we=0.

Test Plan:
- Reset then idle: rst_n=0 -> all outputs 0, in_ready=1. Release with in_valid=0 -> no change.
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7:
  - EXEC cycle: alu_ctrl=1, alu_bsel=0, alu_b=7.
  - T+2: res_valid=1, res_data=12, res_rd=3, res_we=1.
- SUB then backpressure, 0x402081B3, rs1=5, rs2=7, res_ready=0 for 3 cycles:
  - alu_ctrl=9.
  - res_data=0xFFFFFFFE held stable; in_ready=0 until res_ready=1.
- ADDI x5,x0,-1 (0xFFF00293): alu_b=0xFFFFFFFF, alu_bsel=1, alu_ctrl=2, res_we=1. Issue back-to-back with the res_ready handoff -> two results spaced 2 cycles apart.
- SRAI x6,x1,4 (0x4040D313), rs1=0x80000000 -> alu_ctrl=16, res_data=0xF8000000. Same with rd=0 -> res_we=0.
- Illegal word 0x00000000:
  - res_valid=1, res_data=0, res_we=0.
  - With ALU_ISSUE_ILLEGAL_TRAP_EN: res_err=1 and in_ready stays 0 until reset.
